div_ctrl: RTL and testbench



---
 rtl/div_ctrl_pkg.sv | 13 +
 rtl/div_phase_cnt.sv | 40 ++++
 rtl/div_ctrl.sv | 139 +++++++++++++
 tb/tb_div_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the runtime-programmable clock-enable generator.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Smallest divisor that still yields a distinct high and low phase.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_phase_cnt.sv
// Modulo phase counter: counts 0..modulus-1 while enabled, flags the wrap edge.
module div_phase_cnt #(
    parameter int AWIDTH = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [AWIDTH-1:0] modulus,
    output logic [AWIDTH-1:0] phase,
    output logic              wrap
);

    logic [AWIDTH-1:0] phase_reg;
    logic [AWIDTH-1:0] phase_next;
    logic              at_end;

    // ">=" rather than "==" keeps the counter bounded even if the modulus shrinks under it.
    assign at_end = (phase_reg >= (modulus - AWIDTH'(1)));
    assign wrap   = enable && !clear && at_end;
    assign phase  = phase_reg;

    always_comb begin
        phase_next = phase_reg;
        if (clear) begin
            phase_next = '0;
        end else if (enable) begin
            phase_next = at_end ? '0 : (phase_reg + AWIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Clock-enable generator whose divisor can be reprogrammed while running;
// updates take effect only at period boundaries so tick/div_out never glitch.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int AWIDTH      = 20,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              cfg_valid,
    input  logic [AWIDTH-1:0] cfg_div,
    output logic              cfg_ready,
    output logic              cfg_applied,
    output logic              cfg_err,
    output logic              tick,
    output logic              div_out,
    output logic              busy
);

    localparam logic [AWIDTH-1:0] DEF_DIV = AWIDTH'(DEFAULT_DIV);
    localparam logic [AWIDTH-1:0] MIN_N   = AWIDTH'(MIN_DIV);

    state_t            state_reg;
    state_t            state_next;
    logic [AWIDTH-1:0] act_div_reg;
    logic [AWIDTH-1:0] act_div_next;
    logic [AWIDTH-1:0] pend_div_reg;
    logic [AWIDTH-1:0] pend_div_next;
    logic              applied_reg;
    logic              applied_next;
    logic              err_reg;
    logic              err_next;

    logic              handshake;
    logic              div_ok;
    logic              accept;
    logic              cnt_en;
    logic              cnt_clear;
    logic              wrap;
    logic              running;
    logic [AWIDTH-1:0] phase;

    assign cfg_ready = (state_reg != ST_PEND);
    assign handshake = cfg_valid && cfg_ready;
    assign div_ok    = (cfg_div >= MIN_N);
    assign accept    = handshake && div_ok;

    // The counter only advances while running and is held at 0 otherwise,
    // so the first cycle after start (or restart) is always phase 0.
    assign running   = (state_reg != ST_STOP);
    assign cnt_en    = running && run;
    assign cnt_clear = !cnt_en;

    div_phase_cnt #(
        .AWIDTH (AWIDTH)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .modulus (act_div_reg),
        .phase   (phase),
        .wrap    (wrap)
    );

    always_comb begin
        state_next    = state_reg;
        act_div_next  = act_div_reg;
        pend_div_next = pend_div_reg;
        applied_next  = 1'b0;
        err_next      = handshake && !div_ok;

        case (state_reg)
            ST_STOP: begin
                if (accept) begin
                    act_div_next = cfg_div;
                    applied_next = 1'b1;
                end
                if (run) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    // Stopping makes a same-cycle update safe to apply at once.
                    state_next = ST_STOP;
                    if (accept) begin
                        act_div_next = cfg_div;
                        applied_next = 1'b1;
                    end
                end else if (accept) begin
                    pend_div_next = cfg_div;
                    state_next    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!run) begin
                    state_next   = ST_STOP;
                    act_div_next = pend_div_reg;
                    applied_next = 1'b1;
                end else if (wrap) begin
                    // Pulse lands in the first cycle of the new period, with its tick.
                    state_next   = ST_RUN;
                    act_div_next = pend_div_reg;
                    applied_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_STOP;
            act_div_reg  <= DEF_DIV;
            pend_div_reg <= DEF_DIV;
            applied_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            act_div_reg  <= act_div_next;
            pend_div_reg <= pend_div_next;
            applied_reg  <= applied_next;
            err_reg      <= err_next;
        end
    end

    // Pure decode of registered state; no input reaches these outputs.
    assign busy        = running;
    assign tick        = running && (phase == '0);
    assign div_out     = running && (phase < (act_div_reg >> 1));
    assign cfg_applied = applied_reg;
    assign cfg_err     = err_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a period-level behavioural model.
module tb_div_ctrl;

    localparam int AW   = 20;
    localparam int DDIV = 2;
    localparam longint MAXD = (64'd1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [AW-1:0] cfg_div = '0;
    logic          cfg_ready;
    logic          cfg_applied;
    logic          cfg_err;
    logic          tick;
    logic          div_out;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // Model: running flag, cycles into the current period, active/queued divisor.
    bit     m_busy = 0;
    bit     m_has_pend = 0;
    bit     m_applied = 0;
    bit     m_err = 0;
    longint m_act = DDIV;
    longint m_pend = DDIV;
    longint m_pos = 0;

    div_ctrl #(
        .AWIDTH      (AW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_applied (cfg_applied),
        .cfg_err     (cfg_err),
        .tick        (tick),
        .div_out     (div_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] act_vec();
        return {tick, div_out, busy, cfg_ready, cfg_applied, cfg_err};
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_busy && (m_pos == 0), m_busy && (m_pos < m_act / 2), m_busy,
                !m_has_pend, m_applied, m_err};
    endfunction

    // Drive one cycle of inputs, advance one clock edge and the model, settle.
    task automatic step(input bit r, input bit rn, input bit v, input longint d);
        bit hs;
        bit ok;
        longint dd;
        dd = d & MAXD;
        rst = r;
        run = rn;
        cfg_valid = v;
        cfg_div = AW'(dd);
        @(posedge clk);
        hs = v && !m_has_pend;
        ok = (dd >= 2);
        if (r) begin
            m_busy = 0; m_has_pend = 0; m_applied = 0; m_err = 0;
            m_act = DDIV; m_pend = DDIV; m_pos = 0;
        end else begin
            m_applied = 0;
            m_err = hs && !ok;
            if (!m_busy) begin
                if (hs && ok) begin m_act = dd; m_applied = 1; end
                if (rn) begin m_busy = 1; m_pos = 0; end
            end else if (!rn) begin
                m_busy = 0;
                m_pos = 0;
                if (m_has_pend) begin m_act = m_pend; m_has_pend = 0; m_applied = 1; end
                else if (hs && ok) begin m_act = dd; m_applied = 1; end
            end else begin
                if (m_pos == m_act - 1) begin
                    m_pos = 0;
                    if (m_has_pend) begin m_act = m_pend; m_has_pend = 0; m_applied = 1; end
                end else begin
                    m_pos++;
                end
                if (hs && ok) begin m_pend = dd; m_has_pend = 1; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 5);
        checks++;
        if (act_vec() !== 6'b000100) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000100", act_vec());
        end
        step(0, 0, 0, 0);
        checks++;
        if (act_vec() !== 6'b000100) begin
            failures++;
            $display("FAIL reset_idle got=%b want=000100", act_vec());
        end
    endtask

    task automatic test_default_div();
        step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({tick, div_out, busy} !== {(i % 2 == 0), (i % 2 == 0), 1'b1}) begin
                failures++;
                $display("FAIL default_div cyc=%0d tick/div/busy got=%b want=%b", i,
                         {tick, div_out, busy}, {(i % 2 == 0), (i % 2 == 0), 1'b1});
            end
            step(0, 1, 0, 0);
        end
        step(0, 0, 0, 0);
        checks++;
        if ({tick, div_out, busy} !== 3'b000) begin
            failures++;
            $display("FAIL stop_outputs got=%b want=000", {tick, div_out, busy});
        end
    endtask

    task automatic test_stop_write();
        step(0, 0, 1, 7);
        checks++;
        if (cfg_applied !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_write_applied applied=%b busy=%b want applied=1 busy=0",
                     cfg_applied, busy);
        end
        step(0, 1, 0, 0);
        for (int i = 0; i < 21; i++) begin
            checks++;
            if ({tick, div_out, cfg_applied} !== {(i % 7 == 0), (i % 7 < 3), 1'b0}) begin
                failures++;
                $display("FAIL div7 cyc=%0d tick/div/applied got=%b want=%b", i,
                         {tick, div_out, cfg_applied}, {(i % 7 == 0), (i % 7 < 3), 1'b0});
            end
            step(0, 1, 0, 0);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_update_run();
        step(0, 0, 1, 4);
        step(0, 1, 0, 0);             // phase 0
        step(0, 1, 0, 0);             // phase 1
        step(0, 1, 1, 6);             // handshake on the edge leaving phase 1
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cfg_ready, tick, cfg_applied} !== 3'b000) begin
                failures++;
                $display("FAIL update_pend cyc=%0d ready/tick/applied got=%b want=000", i,
                         {cfg_ready, tick, cfg_applied});
            end
            if (i == 0) step(0, 1, 0, 0);
        end
        step(0, 1, 0, 0);
        checks++;
        if ({tick, cfg_applied, cfg_ready} !== 3'b111) begin
            failures++;
            $display("FAIL update_apply tick/applied/ready got=%b want=111",
                     {tick, cfg_applied, cfg_ready});
        end
        for (int j = 1; j <= 6; j++) begin
            step(0, 1, 0, 0);
            checks++;
            if ({tick, div_out} !== {(j == 6), (j < 3 || j == 6)}) begin
                failures++;
                $display("FAIL update_period6 cyc=%0d tick/div got=%b want=%b", j,
                         {tick, div_out}, {(j == 6), (j < 3 || j == 6)});
            end
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_wrap_edge_write();
        step(0, 0, 1, 5);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 4);             // handshake on the wrap edge
        checks++;
        if ({tick, cfg_applied, cfg_ready} !== 3'b100) begin
            failures++;
            $display("FAIL wrap_write_defer tick/applied/ready got=%b want=100",
                     {tick, cfg_applied, cfg_ready});
        end
        for (int j = 1; j <= 5; j++) begin
            step(0, 1, 0, 0);
            checks++;
            if ({tick, cfg_applied} !== {(j == 5), (j == 5)}) begin
                failures++;
                $display("FAIL wrap_write_period5 cyc=%0d tick/applied got=%b want=%b", j,
                         {tick, cfg_applied}, {(j == 5), (j == 5)});
            end
        end
        for (int j = 1; j <= 8; j++) begin
            step(0, 1, 0, 0);
            checks++;
            if (tick !== (j % 4 == 0)) begin
                failures++;
                $display("FAIL wrap_write_period4 cyc=%0d tick got=%b want=%b", j, tick,
                         (j % 4 == 0));
            end
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_reject();
        int n;
        step(0, 0, 1, 4);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        checks++;
        if ({cfg_err, cfg_applied, cfg_ready} !== 3'b101) begin
            failures++;
            $display("FAIL reject_n1 err/applied/ready got=%b want=101",
                     {cfg_err, cfg_applied, cfg_ready});
        end
        step(0, 1, 1, 0);
        checks++;
        if ({cfg_err, cfg_applied} !== 2'b10) begin
            failures++;
            $display("FAIL reject_n0 err/applied got=%b want=10", {cfg_err, cfg_applied});
        end
        step(0, 1, 0, 0);
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reject_pulse_len err got=%b want=0", cfg_err);
        end
        n = 0;
        while (tick !== 1'b1 && n < 10) begin step(0, 1, 0, 0); n++; end
        n = 0;
        do begin step(0, 1, 0, 0); n++; end while (tick !== 1'b1 && n < 20);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL reject_period got=%0d want=4", n);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_stop_in_pend();
        int n;
        step(0, 0, 1, 4);
        step(0, 1, 0, 0);             // phase 0
        step(0, 1, 1, 9);             // queued, now in PEND at phase 1
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_ready got=%b want=0", cfg_ready);
        end
        step(0, 0, 0, 0);
        checks++;
        if (act_vec() !== 6'b000110) begin
            failures++;
            $display("FAIL stop_in_pend got=%b want=000110", act_vec());
        end
        step(0, 1, 0, 0);
        n = 0;
        do begin step(0, 1, 0, 0); n++; end while (tick !== 1'b1 && n < 30);
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL restart_period got=%0d want=9", n);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 1, 5);
        checks++;
        if (act_vec() !== 6'b000100) begin
            failures++;
            $display("FAIL reset_mid got=%b want=000100", act_vec());
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            checks++;
            if ({tick, cfg_applied} !== {(i % 2 == 0), 1'b0}) begin
                failures++;
                $display("FAIL reset_mid_default cyc=%0d tick/applied got=%b want=%b", i,
                         {tick, cfg_applied}, {(i % 2 == 0), 1'b0});
            end
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_large_div();
        step(0, 0, 1, MAXD);
        step(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({tick, div_out, busy} !== {(i == 0), 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL large_div cyc=%0d tick/div/busy got=%b want=%b", i,
                         {tick, div_out, busy}, {(i == 0), 1'b1, 1'b1});
            end
            step(0, 1, 0, 0);
        end
        step(0, 0, 1, 2);
        step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int bad = 0;
        step(1, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            bit r, rn, v;
            longint d;
            r  = ($urandom_range(0, 499) == 0);
            rn = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 5) == 0);
            d  = longint'($urandom_range(0, 12));
            step(r, rn, v, d);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc=%0d tick/div/busy/ready/applied/err got=%b want=%b",
                             c, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_stop_write();
        test_update_run();
        test_wrap_edge_write();
        test_reject();
        test_stop_in_pend();
        test_reset_mid();
        test_large_div();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
